seq_divider: RTL and testbench

- Iterative shift-subtract (restoring) divider for the pipelined CPU's divide path.
- The add/sum datapath computes a+b. This block runs the inverse direction: it produces one quotient bit per cycle by trial subtraction.
- It sits beside the ALU in the execute stage. The pipeline stalls on busy and collects results on done.
- Supports unsigned and signed (truncating toward zero) division.

---
 rtl/seq_divider_if.sv | 55 +++++
 rtl/seq_divider.sv | 215 +++++++++++++++++++++
 tb/tb_seq_divider.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
//
// Request/response bundle between the execute stage and the iterative divider.
//
// Signals:
//   start        requester -> divider  request a divide (taken only while busy=0)
//   signed_op    requester -> divider  1 = two's-complement, 0 = unsigned
//   dividend     requester -> divider  numerator, WIDTH bits
//   divisor      requester -> divider  denominator, WIDTH bits
//   busy         divider -> requester  operation in flight, pipeline must stall
//   done         divider -> requester  one-cycle pulse, results valid
//   quotient     divider -> requester  result quotient, held until next start
//   remainder    divider -> requester  result remainder, held until next start
//   div_by_zero  divider -> requester  divisor was zero, held until next start
//
// Modports: master = execute-stage requester, slave = divider.
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output signed_op,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  signed_op,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Iterative restoring (shift-subtract) divider for the execute-stage divide
// path. One quotient bit is produced per clock by trial subtraction of the
// divisor magnitude from the partial remainder. Signed operands are reduced
// to magnitudes on entry and the signs are re-applied in a single fix-up
// cycle, giving quotients truncated toward zero and remainders that carry the
// sign of the dividend.
//
// Flow: IDLE -> RUN (WIDTH cycles) -> FIX -> DONE -> IDLE
//       IDLE -> DONE directly when the divisor is zero.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any operation in flight
//   div_if   seq_divider_if.slave: start/signed_op/dividend/divisor in,
//            busy/done/quotient/remainder/div_by_zero out (all registered)
//
// Latency: start sampled at edge N gives done high after edge N+WIDTH+2,
// or after edge N+1 for a zero divisor.
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    seq_divider_if.slave div_if
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_C  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_C = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negate when neg is set. The most negative value maps
    // onto itself, which read as unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] cond_negate(
        input logic [WIDTH-1:0] value,
        input logic             neg
    );
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~value + ONE_W;
        end else begin
            res = value;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] prem_q,      prem_d;      // partial remainder
    logic [WIDTH-1:0] quo_q,       quo_d;       // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] dvs_q,       dvs_d;       // divisor magnitude
    logic             sgn_q,       sgn_d;       // latched signed_op
    logic             qneg_q,      qneg_d;      // quotient sign
    logic             rneg_q,      rneg_d;      // remainder sign
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             dvd_neg_s;
    logic             dvs_neg_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] trial_s;
    logic             fits_s;

    // Operand sign detection and the trial subtraction for one RUN step.
    always_comb begin
        dvd_neg_s = div_if.signed_op & div_if.dividend[WIDTH-1];
        dvs_neg_s = div_if.signed_op & div_if.divisor[WIDTH-1];
        // Bring the next dividend bit into the partial remainder.
        shift_s   = {prem_q, quo_q[WIDTH-1]};
        // Two guard bits: the shifted value can exceed WIDTH bits.
        trial_s   = {1'b0, shift_s} - {2'b00, dvs_q};
        // A non-negative difference is always below the divisor and so has
        // both guard bits clear; a negative one has the top bit set.
        fits_s    = (trial_s[WIDTH+1:WIDTH] == 2'b00);
    end

    // Next-state and next-datapath logic for the divider FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sgn_d       = sgn_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (div_if.start) begin
                    sgn_d  = div_if.signed_op;
                    qneg_d = dvd_neg_s ^ dvs_neg_s;
                    rneg_d = dvd_neg_s;
                    quo_d  = cond_negate(div_if.dividend, dvd_neg_s);
                    dvs_d  = cond_negate(div_if.divisor,  dvs_neg_s);
                    if (div_if.divisor == ZERO_W) begin
                        // Zero divisor: results are published right away,
                        // remainder is the raw dividend in either mode.
                        quotient_d  = ONES_W;
                        remainder_d = div_if.dividend;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        prem_d  = ZERO_W;
                        cnt_d   = LAST_C;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (fits_s) begin
                    prem_d = trial_s[WIDTH-1:0];
                end else begin
                    prem_d = shift_s[WIDTH-1:0];
                end
                quo_d = {quo_q[WIDTH-2:0], fits_s};
                if (cnt_q == ZERO_C) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            ST_FIX: begin
                quotient_d  = cond_negate(quo_q,  sgn_q & qneg_q);
                remainder_d = cond_negate(prem_q, sgn_q & rneg_q);
                dbz_d       = 1'b0;
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy covers every non-IDLE state; done is a registered pulse one
        // edge after DONE, so busy has already dropped when done is seen.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= ZERO_C;
            prem_q      <= ZERO_W;
            quo_q       <= ZERO_W;
            dvs_q       <= ZERO_W;
            sgn_q       <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= ZERO_W;
            remainder_q <= ZERO_W;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sgn_q       <= sgn_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 64;
    localparam logic [W-1:0] MIN_W  = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES_W = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset_n;

    seq_divider_if #(.WIDTH(W)) ifc ();

    seq_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_if  (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs [13];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Count edges after the accept edge until done is seen (-1 on timeout).
    task automatic wait_done(output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        while (!found && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (ifc.done === 1'b1) found = 1'b1;
        end
        if (!found) lat = -1;
    endtask

    // Called #1 after a rising edge with busy=0.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        ifc.signed_op = s;
        ifc.dividend  = a;
        ifc.divisor   = b;
        ifc.start     = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        wait_done(lat);
    endtask

    task automatic ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == 64'd0) begin
            q = ONES_W;
            r = a;
            z = 1'b1;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == MIN_W && b == ONES_W) begin
            q = MIN_W;
            r = 64'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    function automatic logic [W-1:0] pick(input int sel);
        logic [W-1:0] v;
        case (sel)
            0:       v = 64'd0;
            1:       v = MIN_W;
            2:       v = ONES_W;
            3:       v = 64'd1;
            4:       v = 64'($urandom_range(0, 20));
            5:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [W-1:0] eq, er;
        logic         ez;
        logic         s;
        logic [W-1:0] a, b;
        bit           seen;

        vecs[0]  = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 66};
        vecs[1]  = '{1'b0, ONES_W, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 66};
        vecs[2]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66};
        vecs[3]  = '{1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 66};
        vecs[4]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66};
        vecs[5]  = '{1'b0, 64'd7, 64'd0, ONES_W, 64'd7, 1'b1, 1};
        vecs[6]  = '{1'b1, MIN_W, ONES_W, MIN_W, 64'd0, 1'b0, 66};
        vecs[7]  = '{1'b0, 64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 66};
        vecs[8]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, ONES_W, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1};
        vecs[9]  = '{1'b0, MIN_W, ONES_W, 64'd0, MIN_W, 1'b0, 66};
        vecs[10] = '{1'b0, 64'd5, 64'd5, 64'd1, 64'd0, 1'b0, 66};
        vecs[11] = '{1'b1, MIN_W, 64'd1, MIN_W, 64'd0, 1'b0, 66};
        vecs[12] = '{1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 66};

        reset_n       = 1'b0;
        ifc.start     = 1'b0;
        ifc.signed_op = 1'b0;
        ifc.dividend  = 64'd0;
        ifc.divisor   = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",      64'(ifc.busy),        64'd0);
        check("reset done",      64'(ifc.done),        64'd0);
        check("reset quotient",  ifc.quotient,         64'd0);
        check("reset remainder", ifc.remainder,        64'd0);
        check("reset dbz",       64'(ifc.div_by_zero), 64'd0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d quotient", i),  ifc.quotient,         vecs[i].q);
            check($sformatf("vec%0d remainder", i), ifc.remainder,        vecs[i].r);
            check($sformatf("vec%0d dbz", i),       64'(ifc.div_by_zero), 64'(vecs[i].z));
            check($sformatf("vec%0d latency", i),   64'(lat),             64'(vecs[i].lat));
            check($sformatf("vec%0d busy at done", i), 64'(ifc.busy),     64'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse width", i), 64'(ifc.done), 64'd0);
        end

        // start while busy is ignored; start in the done cycle is taken
        ifc.signed_op = 1'b0;
        ifc.dividend  = 64'd100;
        ifc.divisor   = 64'd7;
        ifc.start     = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) begin
                ifc.start    = 1'b1;
                ifc.dividend = 64'd9;
                ifc.divisor  = 64'd3;
            end else if (lat == 11) begin
                ifc.start = 1'b0;
            end
            if (ifc.done === 1'b1) seen = 1'b1;
        end
        check("busy-start quotient",  ifc.quotient,  64'd14);
        check("busy-start remainder", ifc.remainder, 64'd2);
        check("busy-start latency",   64'(lat),      64'd66);
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        check("b2b accepted busy", 64'(ifc.busy),  64'd1);
        check("b2b held quotient", ifc.quotient,   64'd14);
        wait_done(lat);
        check("b2b quotient",  ifc.quotient,  64'd3);
        check("b2b remainder", ifc.remainder, 64'd0);
        check("b2b latency",   64'(lat),      64'd66);
        @(posedge clk);
        #1;

        // Random operands including zeros and extremes
        for (int i = 0; i < 250; i++) begin
            s = 1'($urandom_range(0, 1));
            a = pick($urandom_range(0, 9));
            b = pick($urandom_range(0, 9));
            ref_div(s, a, b, eq, er, ez);
            run_op(s, a, b, lat);
            check($sformatf("rand%0d quotient s=%0b a=%h b=%h", i, s, a, b),  ifc.quotient,  eq);
            check($sformatf("rand%0d remainder s=%0b a=%h b=%h", i, s, a, b), ifc.remainder, er);
            check($sformatf("rand%0d dbz", i), 64'(ifc.div_by_zero), 64'(ez));
            check($sformatf("rand%0d latency", i), 64'(lat), ez ? 64'd1 : 64'd66);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of an operation
        run_op(1'b0, 64'd100, 64'd7, lat);
        check("pre-reset quotient", ifc.quotient, 64'd14);
        @(posedge clk);
        #1;
        ifc.dividend = 64'd100;
        ifc.divisor  = 64'd7;
        ifc.start    = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("midreset busy",      64'(ifc.busy),        64'd0);
        check("midreset done",      64'(ifc.done),        64'd0);
        check("midreset quotient",  ifc.quotient,         64'd0);
        check("midreset remainder", ifc.remainder,        64'd0);
        check("midreset dbz",       64'(ifc.div_by_zero), 64'd0);
        #3 reset_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (ifc.done === 1'b1) seen = 1'b1;
        end
        check("no done after abort", 64'(seen), 64'd0);
        run_op(1'b0, 64'd9, 64'd3, lat);
        check("post-reset quotient",  ifc.quotient,  64'd3);
        check("post-reset remainder", ifc.remainder, 64'd0);
        check("post-reset latency",   64'(lat),      64'd66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
